// File: rtl/mux_4_to_1.sv
// 4:1 selector: combinational out, plus out_q/sel_q/sel_chg registered 1 cycle behind when en=1.
// No flow control: en=0 holds out_q/sel_q and drops sel_chg.
module mux_4_to_1 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg
);

    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;
    logic [1:0]       r_sel_q;
    logic             r_sel_chg;

    assign w_sel = {s1, s0};

    // An unknown select yields X in simulation and don't-care in synthesis.
    always_comb begin
        w_out = 'x;
        case (w_sel)
            2'b00:   w_out = in0;
            2'b01:   w_out = in1;
            2'b10:   w_out = in2;
            2'b11:   w_out = in3;
            default: w_out = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q   <= RESET_VAL;
            r_sel_q   <= 2'b00;
            r_sel_chg <= 1'b0;
        end else if (en) begin
            r_out_q   <= w_out;
            r_sel_q   <= w_sel;
            r_sel_chg <= (w_sel != r_sel_q);
        end else begin
            r_sel_chg <= 1'b0;
        end
    end

    assign out     = w_out;
    assign out_q   = r_out_q;
    assign sel_q   = r_sel_q;
    assign sel_chg = r_sel_chg;

endmodule

// File: tb/tb_mux_4_to_1.sv
// Bench for mux_4_to_1: a WIDTH=1 and a WIDTH=8 instance share clock, reset, enable and selects.
module tb_mux_4_to_1;

    localparam logic [7:0] RV8 = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic       d1 [4];
    logic [7:0] d8 [4];

    logic       o1, oq1, chg1;
    logic [1:0] sq1;
    logic [7:0] o8, oq8;
    logic [1:0] sq8;
    logic       chg8;

    // reference state
    logic       eq1;
    logic [7:0] eq8;
    logic [1:0] esel;
    logic       echg;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mux_4_to_1 #(.WIDTH(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en),
        .in0(d1[0]), .in1(d1[1]), .in2(d1[2]), .in3(d1[3]),
        .s1(sel[1]), .s0(sel[0]),
        .out(o1), .out_q(oq1), .sel_q(sq1), .sel_chg(chg1)
    );

    mux_4_to_1 #(.WIDTH(8), .RESET_VAL(RV8)) u_d8 (
        .clk(clk), .rst(rst), .en(en),
        .in0(d8[0]), .in1(d8[1]), .in2(d8[2]), .in3(d8[3]),
        .s1(sel[1]), .s0(sel[0]),
        .out(o8), .out_q(oq8), .sel_q(sq8), .sel_chg(chg8)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out1"},  {7'd0, o1},   {7'd0, d1[sel]});
        chk({tag, ".out8"},  o8,           d8[sel]);
        chk({tag, ".outq1"}, {7'd0, oq1},  {7'd0, eq1});
        chk({tag, ".outq8"}, oq8,          eq8);
        chk({tag, ".selq1"}, {6'd0, sq1},  {6'd0, esel});
        chk({tag, ".selq8"}, {6'd0, sq8},  {6'd0, esel});
        chk({tag, ".chg1"},  {7'd0, chg1}, {7'd0, echg});
        chk({tag, ".chg8"},  {7'd0, chg8}, {7'd0, echg});
    endtask

    // One rising edge; the model applies the register rules to the values present at that edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (en) begin
                echg = (sel != esel);
                esel = sel;
                eq1  = d1[sel];
                eq8  = d8[sel];
            end else begin
                echg = 1'b0;
            end
        end
        #1;
    endtask

    task automatic assert_reset();
        rst  = 1'b1;
        eq1  = 1'b0;
        eq8  = RV8;
        esel = 2'b00;
        echg = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] exp_sweep;
        logic [3:0] exp_chg;
        exp_sweep = 4'b0101; // bit i is the expected out for select i
        exp_chg   = 4'b1110;

        en  = 1'b0;
        sel = 2'b00;
        d1  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) d8[i] = 8'($urandom);
        assert_reset();
        check_all("reset_init");

        // 1: combinational sweep, valid while in reset
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("sweep.out", {7'd0, o1}, {7'd0, exp_sweep[s]});
            chk("sweep.outq_held", {7'd0, oq1}, 8'd0);
        end
        tick();
        check_all("reset_edge_held");

        // 3: registered sweep
        rst = 1'b0;
        en  = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            chk("reg.outq", {7'd0, oq1}, {7'd0, exp_sweep[s]});
            chk("reg.chg",  {7'd0, chg1}, {7'd0, exp_chg[s]});
            check_all("reg");
        end

        // 2: reset between edges clears at once, out still follows
        assert_reset();
        check_all("mid_reset");
        sel = 2'b01;
        #1;
        check_all("mid_reset_sel");
        rst = 1'b0;

        // 4: enable gating
        sel = 2'b11;
        tick();
        check_all("en_load11");
        en  = 1'b0;
        sel = 2'b00;
        tick();
        check_all("en0_hold_a");
        tick();
        check_all("en0_hold_b");
        en = 1'b1;
        tick();
        check_all("reenable");
        chk("reenable.chg", {7'd0, chg1}, 8'd1);

        // 5: data-only change on the held select
        sel   = 2'b10;
        d8[2] = 8'hA5;
        tick();
        tick();
        check_all("data_a5");
        d8[2] = 8'h3C;
        d8[0] = 8'hFF;
        d8[3] = 8'h00;
        #1;
        chk("data.out_now", o8, 8'h3C);
        tick();
        chk("data.outq", oq8, 8'h3C);
        chk("data.chg", {7'd0, chg8}, 8'd0);
        check_all("data");

        // 6: sweep with a reset pulse in the middle
        for (int s = 0; s < 4; s++) begin
            sel = 2'(3 - s);
            tick();
            check_all("sweep6");
            if (s == 1) begin
                assert_reset();
                check_all("sweep6_rst");
                rst = 1'b0;
            end
        end

        // random phase
        for (int k = 0; k < 300; k++) begin
            sel = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                d1[i] = 1'($urandom);
                d8[i] = 8'($urandom);
            end
            #1;
            chk("rand.out1", {7'd0, o1}, {7'd0, d1[sel]});
            chk("rand.out8", o8, d8[sel]);
            tick();
            check_all("rand");
            if ($urandom_range(0, 24) == 0) begin
                assert_reset();
                check_all("rand_rst");
                rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
